lexpander: RTL and testbench
============================

LEXPANDER -- requirements
Module: lexpander

Interface
REQ-001 Parameter ATTACK_SHIFT, default 2, envelope attack shift (1..6).
REQ-002 Parameter RELEASE_SHIFT, default 4, envelope release shift (1..6).
REQ-003 Parameter THRESH_LOG2, default 5, expansion threshold = 2^THRESH_LOG2 (1..6).
REQ-004 Parameter HOLD_SAMPLES, default 4, valid samples held at unity after envelope falls below threshold (1..255).
REQ-005 i_clk  input  1  sole clock, all state on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_valid  input  1  i_data carries a sample this cycle.
REQ-008 i_data  input  8  signed two's-complement sample.
REQ-009 o_valid  output  1  o_data carries an expanded sample this cycle.
REQ-010 o_data  output  8  signed expanded sample.

Function
REQ-011 Block SHALL be a downward expander, the decode-side counterpart of lcompressor; no backpressure, one sample accepted per i_valid cycle.
REQ-012 Stage 1 SHALL register sample and magnitude mag = |i_data|, with -128 saturating to 127 (7-bit unsigned).
REQ-013 Stage 2 SHALL update 7-bit envelope env once per valid sample: mag>env -> env += max(1,(mag-env)>>ATTACK_SHIFT); mag<env -> env -= max(1,(env-mag)>>RELEASE_SHIFT); equal -> unchanged.
REQ-014 Stage 2 SHALL run FSM {EXPAND, OPEN, HOLD} on the updated env: any state with env>=threshold -> OPEN; OPEN with env<threshold -> HOLD, hold counter loaded with HOLD_SAMPLES-1; HOLD decrements per valid sample, counter 0 and env<threshold -> EXPAND.
REQ-015 Stage 3 gain: OPEN/HOLD -> unity, o_data = sample exactly; EXPAND -> gain = env << (8-THRESH_LOG2) (9-bit, always <256), o_data = (sample*gain) >>> 8, arithmetic, floor rounding.
REQ-016 o_valid SHALL assert exactly 3 cycles after the i_valid of the same sample; o_data for sample n SHALL use env/state including sample n.
REQ-017 With i_valid low, env, FSM and hold counter SHALL not change; o_valid low in the corresponding cycle, o_data holds last value.
REQ-018 Back-to-back i_valid SHALL sustain throughput of one sample per cycle.

Reset
REQ-019 i_reset SHALL asynchronously clear o_data=0, o_valid=0, env=0, hold counter=0, pipeline valids=0, FSM=EXPAND.
REQ-020 Reset asserted mid-stream SHALL drop all in-flight samples; no o_valid until 3 cycles after first post-release i_valid.

Structure
REQ-021 Shared package lexpander_pkg SHALL hold FSM state encoding, sample/envelope/gain widths, and default parameter values.
REQ-022 Envelope follower (REQ-013) SHALL be sub-module lexp_envelope; FSM, gain and multiply stay in lexpander.

Verification
REQ-023 Reset: assert i_reset with i_valid=1, i_data=100 -> o_valid=0, o_data=0 immediately and throughout reset.
REQ-024 Attack: from reset, stream 100 every cycle -> env 25, 43, ...; first output 78 (100*200>>8), second onward 100 (OPEN), o_valid 3 cycles after each i_valid.
REQ-025 Hold/expand: after OPEN, stream 10 -> 10 passed unchanged while HOLD lasts (4 samples after env<32), then attenuated outputs (<10) once EXPAND.
REQ-026 Saturation: i_data=-128 stream -> mag 127, once OPEN o_data=-128 exactly.
REQ-027 Gaps: alternate i_valid 1/0 with 100 -> same o_data sequence as REQ-024, o_valid alternating, env unchanged on idle cycles.
REQ-028 Mid-run reset: assert i_reset for 1 cycle while OPEN -> outputs 0, next sample 100 yields 78 again (env restarted from 0).

Source files
------------

// File: rtl/lexpander_pkg.sv
// Shared widths, default parameters and FSM encoding for the lexpander slice.
package lexpander_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned ENV_W    = 7;
  localparam int unsigned GAIN_W   = 9;
  localparam int unsigned HOLD_W   = 8;
  localparam int unsigned PROD_W   = 18;

  localparam int unsigned DEF_ATTACK_SHIFT  = 2;
  localparam int unsigned DEF_RELEASE_SHIFT = 4;
  localparam int unsigned DEF_THRESH_LOG2   = 5;
  localparam int unsigned DEF_HOLD_SAMPLES  = 4;

  typedef enum logic [1:0] {
    EXPAND = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // |s| as 7-bit unsigned; -128 negates to itself (MSB set) and saturates to 127
  function automatic logic [ENV_W-1:0] sat_mag(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] a;
    a = s[SAMPLE_W-1] ? -s : s;
    return a[SAMPLE_W-1] ? '1 : a[ENV_W-1:0];
  endfunction

endpackage

// File: rtl/lexpander_if.sv
// Sample stream bundle: input sample with valid, expanded output with valid.
interface lexpander_if;
  import lexpander_pkg::*;

  logic                i_valid;
  logic [SAMPLE_W-1:0] i_data;
  logic                o_valid;
  logic [SAMPLE_W-1:0] o_data;

  modport master (output i_valid, output i_data, input o_valid, input o_data);
  modport slave  (input i_valid, input i_data, output o_valid, output o_data);

endinterface

// File: rtl/lexp_envelope.sv
// Peak envelope follower with shift-based attack/release and a minimum step of 1.
module lexp_envelope
  import lexpander_pkg::*;
#(
  parameter int unsigned ATTACK_SHIFT  = DEF_ATTACK_SHIFT,
  parameter int unsigned RELEASE_SHIFT = DEF_RELEASE_SHIFT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             en,
  input  logic [ENV_W-1:0] mag,
  output logic [ENV_W-1:0] env,
  output logic [ENV_W-1:0] env_next
);

  logic [ENV_W-1:0] up_step;
  logic [ENV_W-1:0] dn_step;

  always_comb begin
    up_step = (mag - env) >> ATTACK_SHIFT;
    dn_step = (env - mag) >> RELEASE_SHIFT;
    if (up_step == '0) up_step = ENV_W'(1);
    if (dn_step == '0) dn_step = ENV_W'(1);
    env_next = env;
    if (mag > env)      env_next = env + up_step;
    else if (mag < env) env_next = env - dn_step;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)  env <= '0;
    else if (en)  env <= env_next;
  end

endmodule

// File: rtl/lexpander.sv
// Downward expander: 3-stage pipeline (register/magnitude, envelope+FSM, gain).
module lexpander
  import lexpander_pkg::*;
#(
  parameter int unsigned ATTACK_SHIFT  = DEF_ATTACK_SHIFT,
  parameter int unsigned RELEASE_SHIFT = DEF_RELEASE_SHIFT,
  parameter int unsigned THRESH_LOG2   = DEF_THRESH_LOG2,
  parameter int unsigned HOLD_SAMPLES  = DEF_HOLD_SAMPLES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lexpander_if.slave  bus
);

  localparam logic [ENV_W:0] THRESH = (ENV_W+1)'(1 << THRESH_LOG2);

  logic                       s1_valid;
  logic signed [SAMPLE_W-1:0] s1_data;
  logic [ENV_W-1:0]           s1_mag;
  logic                       s2_valid;
  logic signed [SAMPLE_W-1:0] s2_data;
  logic [ENV_W-1:0]           env;
  logic [ENV_W-1:0]           env_next;
  logic                       above;
  state_t                     state;
  logic [HOLD_W-1:0]          hold_cnt;
  logic [GAIN_W-1:0]          gain;
  logic signed [PROD_W-1:0]   prod;

  lexp_envelope #(
    .ATTACK_SHIFT  (ATTACK_SHIFT),
    .RELEASE_SHIFT (RELEASE_SHIFT)
  ) u_env (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .en       (s1_valid),
    .mag      (s1_mag),
    .env      (env),
    .env_next (env_next)
  );

  assign above = {1'b0, env_next} >= THRESH;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mag   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      state    <= EXPAND;
      hold_cnt <= '0;
    end else begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_data <= bus.i_data;
        s1_mag  <= sat_mag(bus.i_data);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s1_data;
        if (above) begin
          state <= OPEN;
        end else begin
          case (state)
            OPEN: begin
              state    <= HOLD;
              hold_cnt <= HOLD_W'(HOLD_SAMPLES - 1);
            end
            HOLD: begin
              if (hold_cnt == '0) state    <= EXPAND;
              else                hold_cnt <= hold_cnt - 1'b1;
            end
            default: state <= EXPAND;
          endcase
        end
      end
    end
  end

  // env and state still hold the values produced by the sample now in stage 3,
  // since a following sample only overwrites them on this same edge.
  always_comb begin
    gain = GAIN_W'(env) << (8 - THRESH_LOG2);
    prod = PROD_W'(s2_data) * PROD_W'($signed({1'b0, gain}));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
    end else begin
      bus.o_valid <= s2_valid;
      if (s2_valid)
        bus.o_data <= (state == EXPAND) ? SAMPLE_W'(prod >>> 8) : s2_data;
    end
  end

endmodule

// File: tb/tb_lexpander.sv
// Bench for lexpander: directed phases plus random traffic against a sample-level model.
module tb_lexpander;

  localparam int A  = 2;
  localparam int R  = 4;
  localparam int TL = 5;
  localparam int H  = 4;

  logic clk;
  logic i_reset;
  lexpander_if bus ();

  lexpander #(
    .ATTACK_SHIFT  (A),
    .RELEASE_SHIFT (R),
    .THRESH_LOG2   (TL),
    .HOLD_SAMPLES  (H)
  ) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int m_env    = 0;
  int m_budget = 0;

  bit         pipe_v[3];
  logic [7:0] pipe_d[3];
  logic [7:0] last_exp = '0;
  logic [7:0] cap[$];
  logic [7:0] mexp[$];
  logic [7:0] atk_exp[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Per-sample reference: envelope rule, then unity while loud or within the
  // hold budget after going quiet, else scale by env/threshold with floor.
  function automatic int model(input int d);
    int mag, step, g, p;
    mag = (d == -128) ? 127 : ((d < 0) ? -d : d);
    if (mag > m_env) begin
      step = (mag - m_env) / (1 << A);
      m_env += (step < 1) ? 1 : step;
    end else if (mag < m_env) begin
      step = (m_env - mag) / (1 << R);
      m_env -= (step < 1) ? 1 : step;
    end
    if (m_env >= (1 << TL)) begin
      m_budget = H;
      return d;
    end
    if (m_budget > 0) begin
      m_budget--;
      return d;
    end
    g = m_env * (1 << (8 - TL));
    p = d * g;
    return (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endfunction

  task automatic cyc(input bit v, input int d);
    @(posedge clk);
    #1;
    if (pipe_v[2]) last_exp = pipe_d[2];
    chk("o_valid", {7'b0, bus.o_valid}, {7'b0, pipe_v[2]});
    chk("o_data", bus.o_data, last_exp);
    if (bus.o_valid) cap.push_back(bus.o_data);
    pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
    pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
    bus.i_valid = v;
    bus.i_data  = 8'(d);
    pipe_v[0] = v;
    if (v) begin
      pipe_d[0] = 8'(model(d));
      mexp.push_back(pipe_d[0]);
    end
  endtask

  task automatic drain();
    repeat (4) cyc(1'b0, 0);
  endtask

  task automatic do_reset(input int n);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'd100;
    i_reset     = 1'b1;
    #1;
    chk("rst_o_valid", {7'b0, bus.o_valid}, 8'd0);
    chk("rst_o_data", bus.o_data, 8'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_o_valid", {7'b0, bus.o_valid}, 8'd0);
      chk("rst_o_data", bus.o_data, 8'd0);
    end
    i_reset     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    m_env = 0;
    m_budget = 0;
    for (int i = 0; i < 3; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    last_exp = '0;
    cap.delete();
    mexp.delete();
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    i_reset     = 1'b0;

    do_reset(3);

    // attack from silence
    repeat (12) cyc(1'b1, 100);
    repeat (3) cyc(1'b0, 0);
    chk("atk_count", 8'(cap.size()), 8'd12);
    if (cap.size() >= 2) begin
      chk("atk_first", cap[0], 8'd78);
      chk("atk_second", cap[1], 8'd100);
    end
    atk_exp = mexp;

    // quiet tail: held at unity, then attenuated
    cap.delete();
    repeat (60) cyc(1'b1, 10);
    drain();
    if (cap.size() > 0) begin
      chk("hold_first", cap[0], 8'd10);
      tests++;
      assert ($signed(cap[$]) < 10) else begin
        fails++;
        $error("FAIL hold_expand_atten: observed %0d, expected < 10", $signed(cap[$]));
      end
    end

    // -128 saturates magnitude, passes exactly once open
    do_reset(1);
    repeat (12) cyc(1'b1, -128);
    drain();
    if (cap.size() > 0) chk("sat_last", cap[$], 8'h80);

    // alternating gaps reproduce the attack sequence
    do_reset(1);
    for (int i = 0; i < 16; i++) cyc((i % 2) == 0, 100);
    drain();
    chk("gap_count", 8'(cap.size()), 8'd8);
    for (int i = 0; i < 8 && i < cap.size() && i < atk_exp.size(); i++)
      chk("gap_seq", cap[i], atk_exp[i]);

    // reset while open drops in-flight samples and restarts env
    do_reset(1);
    repeat (6) cyc(1'b1, 100);
    do_reset(1);
    cyc(1'b1, 100);
    drain();
    chk("rst_restart_count", 8'(cap.size()), 8'd1);
    if (cap.size() > 0) chk("rst_restart", cap[0], 8'd78);

    // random traffic in loud/quiet bursts
    do_reset(1);
    for (int blk = 0; blk < 16; blk++) begin
      bit loud;
      loud = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 32; i++) begin
        int d;
        d = loud ? (int'($urandom_range(0, 255)) - 128) : (int'($urandom_range(0, 40)) - 20);
        cyc($urandom_range(0, 3) != 0, d);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
